// File: rtl/bp_update_ctrl_pkg.sv
// Shared types, state encodings and helpers for the branch-predictor update controller.
// Imported by the queue, the controller and its interface.
package bp_update_ctrl_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [0:0] BPC_RUN   = 1'b0;
  localparam logic [0:0] BPC_DRAIN = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Bundle of prediction, resolution, update and status signals around bp_update_ctrl.
// master = fetch/execute/ctrl side, slave = the controller.
interface bp_update_ctrl_if #(parameter int DEPTH = 4);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          pred_valid_i;
  logic [31:0]   pred_pc_i;
  logic          pred_taken_i;
  logic [31:0]   pred_target_i;
  logic          pred_ready_o;
  logic          res_valid_i;
  logic          res_taken_i;
  logic [31:0]   res_target_i;
  logic          upd_valid_o;
  logic [31:0]   upd_pc_o;
  logic          upd_taken_o;
  logic          flush_o;
  logic [31:0]   redirect_addr_o;
  logic [CW-1:0] occupancy_o;
  logic [15:0]   hit_cnt_o;
  logic [15:0]   miss_cnt_o;
  logic          err_o;

  modport master (
    output pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
    output res_valid_i, res_taken_i, res_target_i,
    input  pred_ready_o, upd_valid_o, upd_pc_o, upd_taken_o, flush_o,
    input  redirect_addr_o, occupancy_o, hit_cnt_o, miss_cnt_o, err_o
  );

  modport slave (
    input  pred_valid_i, pred_pc_i, pred_taken_i, pred_target_i,
    input  res_valid_i, res_taken_i, res_target_i,
    output pred_ready_o, upd_valid_o, upd_pc_o, upd_taken_o, flush_o,
    output redirect_addr_o, occupancy_o, hit_cnt_o, miss_cnt_o, err_o
  );

endinterface

// File: rtl/bp_update_ctrl_fifo.sv
// In-order queue of in-flight predictions {pc, taken, target} with single-cycle flush.
// The caller guarantees push only when not full and pop only when not empty.
module bp_update_ctrl_fifo
  import bp_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  bp_entry_t              i_data,
  output bp_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  bp_entry_t     r_mem [DEPTH];

  // Entry storage; a flushed push is wrong-path and never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor training and mispredict recovery: tracks in-flight predictions,
// trains the predictor on resolution, and flushes/redirects then drains on a mispredict.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  bp_update_ctrl_if.slave   bus
);

  localparam int         CW         = $clog2(DEPTH) + 1;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  logic [0:0]    r_state;
  logic [3:0]    r_drain_cnt;
  logic          r_upd_valid;
  logic [31:0]   r_upd_pc;
  logic          r_upd_taken;
  logic          r_flush;
  logic [31:0]   r_redirect;
  logic [15:0]   r_hit_cnt;
  logic [15:0]   r_miss_cnt;
  logic          r_err;

  bp_entry_t     w_head;
  bp_entry_t     w_new;
  logic [CW-1:0] w_count;
  logic          w_run;
  logic          w_ready;
  logic          w_mis;
  logic          w_pop;
  logic          w_flush;
  logic          w_push;
  logic          w_empty_res;
  logic [31:0]   w_redirect;

  assign w_run       = (r_state == BPC_RUN);
  assign w_ready     = w_run && (w_count != CW'(DEPTH));
  assign w_mis       = (bus.res_taken_i != w_head.taken) ||
                       (bus.res_taken_i && (bus.res_target_i != w_head.target));
  assign w_pop       = w_run && bus.res_valid_i && (w_count != '0);
  assign w_flush     = w_pop && w_mis;
  // A push in the same cycle as a mispredict is on the wrong path
  assign w_push      = w_ready && bus.pred_valid_i && !w_flush;
  assign w_empty_res = w_run && bus.res_valid_i && (w_count == '0);
  assign w_redirect  = bus.res_taken_i ? bus.res_target_i : (w_head.pc + 32'd4);
  assign w_new       = '{pc: bus.pred_pc_i, taken: bus.pred_taken_i, target: bus.pred_target_i};

  bp_update_ctrl_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_new),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // RUN/DRAIN sequencing with the post-flush drain window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= BPC_RUN;
      r_drain_cnt <= 4'd0;
    end else begin
      case (r_state)
        BPC_RUN: begin
          if (w_flush) begin
            r_state     <= BPC_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        BPC_DRAIN: begin
          if (r_drain_cnt <= 4'd1) begin
            r_state     <= BPC_RUN;
            r_drain_cnt <= 4'd0;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
        default: begin
          r_state     <= BPC_RUN;
          r_drain_cnt <= 4'd0;
        end
      endcase
    end
  end

  // One-cycle predictor update and flush/redirect pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upd_valid <= 1'b0;
      r_upd_pc    <= ZERO_WORD;
      r_upd_taken <= 1'b0;
      r_flush     <= 1'b0;
      r_redirect  <= ZERO_WORD;
    end else begin
      r_upd_valid <= w_pop;
      r_upd_pc    <= w_pop ? w_head.pc : ZERO_WORD;
      r_upd_taken <= w_pop && bus.res_taken_i;
      r_flush     <= w_flush;
      r_redirect  <= w_flush ? w_redirect : ZERO_WORD;
    end
  end

  // Saturating statistics and the sticky empty-resolve error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= 16'd0;
      r_miss_cnt <= 16'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_pop && !w_mis) begin
        r_hit_cnt <= sat_inc16(r_hit_cnt);
      end
      if (w_flush) begin
        r_miss_cnt <= sat_inc16(r_miss_cnt);
      end
      if (w_empty_res) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.pred_ready_o    = w_ready;
  assign bus.upd_valid_o     = r_upd_valid;
  assign bus.upd_pc_o        = r_upd_pc;
  assign bus.upd_taken_o     = r_upd_taken;
  assign bus.flush_o         = r_flush;
  assign bus.redirect_addr_o = r_redirect;
  assign bus.occupancy_o     = w_count;
  assign bus.hit_cnt_o       = r_hit_cnt;
  assign bus.miss_cnt_o      = r_miss_cnt;
  assign bus.err_o           = r_err;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: a reference queue model predicts each cycle's
// registered outputs, which are pushed to a scoreboard and compared after the edge.
module tb_bp_update_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef struct {
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        flush;
    logic [31:0] redirect;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ent_t        mq[$];
  exp_t        sb[$];
  logic        m_drain;
  int          m_cnt;
  logic [15:0] m_hit;
  logic [15:0] m_miss;
  logic        m_err;

  bp_update_ctrl_if #(.DEPTH(4)) bus ();

  bp_update_ctrl #(.DEPTH(4), .DRAIN_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_drain = 1'b0;
    m_cnt   = 0;
    m_hit   = 16'd0;
    m_miss  = 16'd0;
    m_err   = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".occ"},   32'(bus.occupancy_o),  32'(mq.size()));
    chk({tag, ".ready"}, 32'(bus.pred_ready_o), 32'(!m_drain && (mq.size() < 4)));
    chk({tag, ".hit"},   32'(bus.hit_cnt_o),    32'(m_hit));
    chk({tag, ".miss"},  32'(bus.miss_cnt_o),   32'(m_miss));
    chk({tag, ".err"},   32'(bus.err_o),        32'(m_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".upd_valid"}, 32'(bus.upd_valid_o), 32'd0);
    chk({tag, ".upd_pc"},    bus.upd_pc_o,          32'd0);
    chk({tag, ".upd_taken"}, 32'(bus.upd_taken_o), 32'd0);
    chk({tag, ".flush"},     32'(bus.flush_o),     32'd0);
    chk({tag, ".redirect"},  bus.redirect_addr_o,   32'd0);
    chk({tag, ".occ"},       32'(bus.occupancy_o), 32'd0);
    chk({tag, ".ready"},     32'(bus.pred_ready_o), 32'd1);
    chk({tag, ".hit"},       32'(bus.hit_cnt_o),   32'd0);
    chk({tag, ".miss"},      32'(bus.miss_cnt_o),  32'd0);
    chk({tag, ".err"},       32'(bus.err_o),       32'd0);
  endtask

  // One clock: drive inputs, advance the model, compare one scoreboard entry after the edge
  task automatic cycle(input string tag,
                       input logic pv, input logic [31:0] ppc, input logic ptk, input logic [31:0] ptg,
                       input logic rv, input logic rtk, input logic [31:0] rtg);
    exp_t e;
    ent_t h;
    ent_t n;
    logic run;
    logic ready;
    logic mis;
    exp_t got;
    bus.pred_valid_i  = pv;
    bus.pred_pc_i     = ppc;
    bus.pred_taken_i  = ptk;
    bus.pred_target_i = ptg;
    bus.res_valid_i   = rv;
    bus.res_taken_i   = rtk;
    bus.res_target_i  = rtg;
    e     = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0};
    n     = '{ppc, ptk, ptg};
    run   = !m_drain;
    ready = run && (mq.size() < 4);
    mis   = 1'b0;
    if (run && rv && mq.size() != 0) begin
      h   = mq.pop_front();
      mis = (rtk != h.taken) || (rtk && (rtg != h.target));
      e.upd_valid = 1'b1;
      e.upd_pc    = h.pc;
      e.upd_taken = rtk;
      if (mis) begin
        e.flush    = 1'b1;
        e.redirect = rtk ? rtg : h.pc + 32'd4;
        mq.delete();
        m_miss  = (m_miss == 16'hFFFF) ? m_miss : m_miss + 16'd1;
        m_drain = 1'b1;
        m_cnt   = 2;
      end else begin
        m_hit = (m_hit == 16'hFFFF) ? m_hit : m_hit + 16'd1;
      end
    end else if (run && rv) begin
      m_err = 1'b1;
    end
    if (ready && pv && !mis) mq.push_back(n);
    if (!run) begin
      m_cnt = m_cnt - 1;
      if (m_cnt <= 0) begin
        m_drain = 1'b0;
        m_cnt   = 0;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.pred_valid_i = 1'b0;
    bus.res_valid_i  = 1'b0;
    got = sb.pop_front();
    chk({tag, ".upd_valid"}, 32'(bus.upd_valid_o), 32'(got.upd_valid));
    chk({tag, ".upd_pc"},    bus.upd_pc_o,          got.upd_pc);
    chk({tag, ".upd_taken"}, 32'(bus.upd_taken_o), 32'(got.upd_taken));
    chk({tag, ".flush"},     32'(bus.flush_o),     32'(got.flush));
    chk({tag, ".redirect"},  bus.redirect_addr_o,   got.redirect);
    chk_status(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst = 1'b0;
    bus.pred_valid_i = 1'b0; bus.pred_pc_i = 32'd0; bus.pred_taken_i = 1'b0; bus.pred_target_i = 32'd0;
    bus.res_valid_i  = 1'b0; bus.res_taken_i = 1'b0; bus.res_target_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    // single hit
    cycle("hit_push", 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'd0);
    cycle("hit_res",  1'b0, 32'd0,   1'b0, 32'd0,  1'b1, 1'b1, 32'h80);
    chk("hit.cnt_direct", 32'(bus.hit_cnt_o), 32'd1);

    // direction mispredict: predicted not-taken, resolved taken
    cycle("dir_push", 1'b1, 32'h200, 1'b0, 32'h204, 1'b0, 1'b0, 32'd0);
    cycle("dir_res",  1'b0, 32'd0,   1'b0, 32'd0,   1'b1, 1'b1, 32'h240);
    chk("dir.redirect_direct", bus.redirect_addr_o, 32'h240);
    chk("dir.ready_low0", 32'(bus.pred_ready_o), 32'd0);
    idle("dir_drain1");
    chk("dir.ready_low1", 32'(bus.pred_ready_o), 32'd0);
    idle("dir_drain2");
    chk("dir.ready_back", 32'(bus.pred_ready_o), 32'd1);

    // predicted taken, resolved not-taken at the top of the address space
    cycle("wrap_push", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1000, 1'b0, 1'b0, 32'd0);
    cycle("wrap_res",  1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk("wrap.redirect_direct", bus.redirect_addr_o, 32'h0000_0000);
    idle("wrap_d1");
    idle("wrap_d2");

    // full queue, then simultaneous push+pop while full
    for (int i = 0; i < 4; i++) begin
      cycle("full_push", 1'b1, 32'h10 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    end
    chk("full.ready_direct", 32'(bus.pred_ready_o), 32'd0);
    cycle("full_pushpop", 1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0);
    chk("full.occ_direct", 32'(bus.occupancy_o), 32'd3);
    for (int i = 0; i < 3; i++) begin
      cycle("full_drain", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    end

    // squash: mispredict with same-cycle push, then activity during DRAIN
    cycle("sq_push", 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    cycle("sq_mis",  1'b1, 32'h304, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400);
    cycle("sq_d1",   1'b1, 32'h400, 1'b1, 32'h500, 1'b1, 1'b1, 32'h500);
    cycle("sq_d2",   1'b1, 32'h404, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0);
    chk("sq.occ_direct", 32'(bus.occupancy_o), 32'd0);
    chk("sq.err_direct", 32'(bus.err_o), 32'd0);

    // empty resolve sets the sticky error
    cycle("empty_res", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0);
    chk("empty.err_direct", 32'(bus.err_o), 32'd1);
    idle("empty_hold");

    // asynchronous reset in the middle of DRAIN
    cycle("rst_push", 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    cycle("rst_mis",  1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h600);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle("post_push", 1'b1, 32'h700, 1'b1, 32'h720, 1'b0, 1'b0, 32'd0);
    cycle("post_res",  1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h720);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

- Sequences training and recovery for the fetch-stage branch predictor.
- Tracks every predicted branch/JAL in an in-order queue from fetch until the execute stage resolves it.
- On resolution, drives the predictor's update inputs (`last_need_predict`, `last_addr`, `last_jump`) and detects mispredictions. A mispredict triggers a pipeline flush and redirect, followed by a fixed drain window.
- Sits between the IF-stage predictor, the execute-stage branch unit and the pipeline control (ctrl) block.

## Interface
Parameters:
- DEPTH, 4: in-flight queue entries; power of two, 2..16.
- DRAIN_CYCLES, 2: cycles after a flush during which new predictions are refused; range 1..15.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (`RstEnable` = 0).
- pred_valid_i  in  1  fetch issued a JAL/B-type with a prediction this cycle.
- pred_pc_i  in  32  PC of that instruction.
- pred_taken_i  in  1  predicted direction.
- pred_target_i  in  32  predicted target.
- pred_ready_o  out  1  queue accepts a prediction; low stalls fetch.
- res_valid_i  in  1  execute resolved the oldest in-flight branch.
- res_taken_i  in  1  actual direction.
- res_target_i  in  32  actual target (meaningful when taken).
- upd_valid_o  out  1  predictor update strobe; wires to `last_need_predict_i`.
- upd_pc_o  out  32  PC to train; wires to `last_addr_i`.
- upd_taken_o  out  1  outcome; wires to `last_jump_i`.
- flush_o  out  1  one-cycle flush request to ctrl.
- redirect_addr_o  out  32  correct fetch address, valid while flush_o = 1.
- occupancy_o  out  $clog2(DEPTH)+1  entries currently queued.
- hit_cnt_o  out  16  correct predictions, saturating.
- miss_cnt_o  out  16  mispredictions, saturating.
- err_o  out  1  sticky: a resolution arrived with the queue empty.

## Operation
FSM states: RUN and DRAIN. Reset state is RUN.

RUN behaviour:
- pred_ready_o = (occupancy < DEPTH).
- Push: occurs when pred_valid_i && pred_ready_o; stores {pc, taken, target} at the tail.
- Pop: occurs when res_valid_i && occupancy != 0; pops the head.
  - Push and pop in the same cycle are both legal.
  - A full queue cannot push in that cycle, even if a pop happens, because ready is not combinational on res_valid_i.

Per pop:
- Registered update: upd_valid_o = 1, upd_pc_o = head.pc, upd_taken_o = res_taken_i.
- Mispredict = (res_taken_i != head.taken) || (res_taken_i && res_target_i != head.target).
- Hit: hit_cnt_o increments, saturating at 16'hFFFF.
- Mispredict:
  - miss_cnt_o increments, saturating.
  - flush_o pulses.
  - redirect_addr_o = res_taken_i ? res_target_i : head.pc + 4, with 32-bit wrap.
  - The entire queue is cleared.
  - Any same-cycle push is discarded as wrong-path.
  - The drain counter loads DRAIN_CYCLES and the FSM goes to DRAIN.

DRAIN behaviour:
- pred_ready_o = 0; pred_valid_i and res_valid_i are ignored (squashed instructions).
- The counter decrements each cycle; on reaching 0 the FSM returns to RUN.

Other rules:
- A resolution with the queue empty in RUN sets err_o; it is cleared only by reset and causes no other effect.
- Queue pointers wrap modulo DEPTH.

## Timing
- Reset values: queue empty, occupancy_o = 0, pred_ready_o = 1, all upd_*, flush_o, redirect_addr_o, hit/miss counters and err_o = 0, FSM in RUN.
- Reset assertion mid-operation clears everything immediately (asynchronous).
- upd_*, flush_o, redirect_addr_o, the counters and err_o are registered: they appear one cycle after the res_valid_i edge and last exactly one cycle, except the counters and err_o.
- On a mispredict, DRAIN covers the DRAIN_CYCLES edges that follow the one registering flush_o. pred_ready_o returns to 1 on cycle DRAIN_CYCLES+1 after that edge.
- Throughput: one push and one pop per cycle in RUN.

## Structure
- defines.v gains the state encodings `BpcRun` and `BpcDrain`. Existing `InstAddrBus` / `ZeroWord` are reused.
- One natural sub-module: bp_fifo, a parameterised synchronous FIFO with flush, carrying {pc, taken, target}. bp_update_ctrl holds the FSM, compare logic, output registers and counters.

## Test plan
- Single hit: push pc 0x100, taken, target 0x80; resolve taken/0x80. Next cycle upd_valid_o = 1, upd_pc_o = 0x100, upd_taken_o = 1; flush_o = 0; hit_cnt_o = 1.
- Direction mispredict: push pc 0x200, not-taken; resolve taken/0x240. flush_o = 1, redirect_addr_o = 0x240, occupancy_o = 0, pred_ready_o low for 2 cycles, miss_cnt_o = 1.
- Taken-predicted, actually not-taken: pc 0xFFFFFFFC. redirect_addr_o = 0x00000000 (wrap).
- Full queue: 4 pushes, then pred_ready_o = 0. A simultaneous push and pop while full leaves occupancy 3 the next cycle; the push is refused.
- Squash: mispredict with a same-cycle push, then pred_valid_i/res_valid_i during DRAIN. occupancy_o stays 0; counters are unchanged except miss_cnt_o.
- Empty resolve and reset: res_valid_i with the queue empty sets err_o; asserting rst mid-DRAIN returns all outputs to reset values without waiting for a clock edge.
